dmem_responder: RTL

- Data-memory responder: the target side of the core's load/store memory interface.
- Accepts one word-oriented request at a time over a valid/ready handshake.
- Performs the read or byte-masked write against an internal word array.
- Returns a response after a programmable latency; the response is held until the initiator accepts it.
- Replaces the zero-latency data array so the load/store path can be exercised against a realistic slow memory.

---
 rtl/dmem_responder.sv | 118 +++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, commits it on the
// acceptance edge and presents a registered response after LATENCY cycles.
module dmem_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_wen,
  input  logic [3:0]  req_wstrb,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] ADDR_LAST = ADDR_BASE + 32'(4 * DEPTH_WORDS) - 32'd1;
  localparam logic [3:0]  LAT_INIT  = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [31:0] rdata_reg, rdata_next;
  logic        err_reg, err_next;

  logic          accept;
  logic          in_range;
  logic [AW-1:0] word_idx;
  logic [31:0]   mem_rdata;
  logic [3:0]    lane_we;

  assign in_range = (req_addr >= ADDR_BASE) && (req_addr <= ADDR_LAST);
  assign word_idx = AW'((req_addr - ADDR_BASE) >> 2);
  assign accept   = (state_reg == IDLE) && req_valid;

  // One byte-wide array per lane so byte-masked stores need no read-modify-write.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH_WORDS];

      assign lane_we[gi] = accept && req_wen && in_range && req_wstrb[gi];

      always_ff @(posedge clk) begin
        if (lane_we[gi]) begin
          mem[word_idx] <= req_wdata[8*gi +: 8];
        end
      end

      assign mem_rdata[8*gi +: 8] = mem[word_idx];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      rdata_reg <= 32'd0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rdata_reg <= rdata_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rdata_next = rdata_reg;
    err_next   = err_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          // Load data is sampled at acceptance so the response is immune to later stores.
          rdata_next = (in_range && !req_wen) ? mem_rdata : 32'd0;
          err_next   = !in_range;
          if (LATENCY == 1) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = LAT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_reg == 4'd1) begin
          state_next = RESP;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_next = IDLE;
          rdata_next = 32'd0;
          err_next   = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign req_ready  = (state_reg == IDLE);
  assign resp_valid = (state_reg == RESP);
  assign resp_rdata = rdata_reg;
  assign resp_err   = err_reg;

endmodule
